pipe_skid_reg: RTL
==================

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameter DATA_W, default 96, payload width in bits; PC, instruction and PC+4 concatenated for IF/ID use.
REQ-002 Parameter RST_DATA, default {32'h0, 32'h00000013, 32'h4}, payload value loaded on reset and flush (NOP bubble).
REQ-003 i_clk  input  1  single clock; all state updates on its rising edge.
REQ-004 i_rst  input  1  reset, asynchronous, active-high.
REQ-005 i_flush  input  1  synchronous flush; discards all held entries.
REQ-006 i_valid  input  1  upstream payload valid.
REQ-007 o_ready  output  1  stage can accept an upstream payload this cycle.
REQ-008 i_data  input  DATA_W  upstream payload.
REQ-009 o_valid  output  1  downstream payload valid.
REQ-010 i_ready  input  1  downstream accepts o_data this cycle (0 = stall).
REQ-011 o_data  output  DATA_W  downstream payload.
REQ-012 o_count  output  2  number of held entries, 0..2.

Function
REQ-013 Definitions: in_fire = i_valid & o_ready; out_fire = o_valid & i_ready.
REQ-014 The block SHALL hold two slots: main (drives o_data) and skid, under a three-state FSM EMPTY, ONE, TWO.
REQ-015 o_valid SHALL be 1 exactly in ONE or TWO; o_ready SHALL be 1 exactly in EMPTY or ONE; o_count SHALL be 0/1/2 for EMPTY/ONE/TWO.
REQ-016 o_ready SHALL be decoded from state registers only, with no combinational path from i_ready or i_valid.
REQ-017 EMPTY: in_fire -> main <= i_data, go ONE; otherwise hold.
REQ-018 ONE: in_fire & out_fire -> main <= i_data, stay ONE; out_fire only -> EMPTY; in_fire only -> skid <= i_data, go TWO; neither -> hold.
REQ-019 TWO: out_fire -> main <= skid, go ONE; otherwise hold; no input is accepted.
REQ-020 Latency: a payload accepted in cycle N SHALL appear on o_data with o_valid=1 in cycle N+1 when the stage was EMPTY or drained in cycle N.
REQ-021 Ordering SHALL be strict FIFO; no payload is duplicated or dropped except by flush or reset.
REQ-022 i_flush=1 SHALL, at the next edge, force EMPTY, load main and skid with RST_DATA, and drop any in_fire of that cycle; flush takes priority over every transition in REQ-017..019.
REQ-023 When EMPTY, o_data SHALL equal the last value in main (RST_DATA after reset or flush).
REQ-024 Simultaneous i_flush and out_fire: downstream is deemed to have consumed o_data that cycle; the stage still goes EMPTY.
REQ-025 Throughput SHALL be one payload per cycle when i_ready stays 1.

Reset
REQ-026 i_rst=1 SHALL immediately, without waiting for a clock edge, set state EMPTY, main = skid = RST_DATA, o_valid=0, o_ready=1, o_count=0.
REQ-027 Reset asserted mid-operation SHALL discard both slots; the first edge after deassertion behaves as EMPTY.
REQ-028 Reset SHALL take priority over i_flush and all handshakes.

Structure
REQ-029 FSM state encoding (EMPTY, ONE, TWO) and the default NOP payload constant SHALL reside in the shared pipeline package.
REQ-030 No sub-module is required; one flat module, about 150 lines.
REQ-031 Instances SHALL replace the fixed-width IF/ID register by setting DATA_W=96; the legacy i_write stall maps to i_ready.

Verification
REQ-032 Reset then idle: o_valid=0, o_ready=1, o_count=0, o_data=RST_DATA; assert i_rst between edges -> outputs change before the next edge.
REQ-033 Streaming: i_ready=1, push 0x1,0x2,0x3 on consecutive cycles -> o_data 0x1,0x2,0x3 one cycle later each, o_count stays 1, o_ready stays 1.
REQ-034 Backpressure: i_ready=0, push 0xA,0xB -> o_count=2, o_ready=0, 0xC held upstream; release i_ready -> outputs 0xA,0xB,0xC in order with no loss.
REQ-035 Flush in TWO with i_valid=1 carrying 0xD: next cycle o_valid=0, o_count=0, o_data=RST_DATA; 0xD never appears.
REQ-036 Flush and out_fire in the same cycle in ONE: stage goes EMPTY; downstream sees the held payload exactly once.
REQ-037 Random valid/ready/flush for 10k cycles against a reference queue model: order preserved, o_count matches, o_ready never depends on same-cycle i_ready.

Source files
------------

// File: rtl/pipe_skid_reg_pkg.sv
// Shared pipeline definitions: skid-buffer FSM encoding and the NOP bubble payload.
package pipe_skid_reg_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_e;

  // PC = 0, instruction = addi x0,x0,0 (NOP), PC+4 = 4
  localparam logic [95:0] NOP_PAYLOAD = {32'h0, 32'h00000013, 32'h4};

endpackage

// File: rtl/pipe_skid_reg.sv
// Two-entry skid pipeline register; o_ready comes only from state, so the
// downstream ready never reaches upstream combinationally.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_EMPTY | no entries held; o_data shows last main value
// ST_ONE   | main holds the head entry; still accepting
// ST_TWO   | main holds head, skid holds the next; upstream stalled
module pipe_skid_reg
  import pipe_skid_reg_pkg::*;
#(
  parameter int                 DATA_W   = 96,
  parameter logic [DATA_W-1:0]  RST_DATA = DATA_W'(NOP_PAYLOAD)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_flush,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic [1:0]        o_count
);

  skid_state_e       state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_fire, out_fire;

  assign o_valid  = (state_q == ST_ONE) || (state_q == ST_TWO);
  assign o_ready  = (state_q == ST_EMPTY) || (state_q == ST_ONE);
  assign o_data   = main_q;
  assign in_fire  = i_valid & o_ready;
  assign out_fire = o_valid & i_ready;

  always_comb begin
    o_count = 2'd0;
    case (state_q)
      ST_ONE:  o_count = 2'd1;
      ST_TWO:  o_count = 2'd2;
      default: o_count = 2'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (i_flush) begin
      // a same-cycle out_fire still counts as consumed; any in_fire is dropped
      state_d = ST_EMPTY;
      main_d  = RST_DATA;
      skid_d  = RST_DATA;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            main_d  = i_data;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_d = i_data;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end else if (in_fire) begin
            skid_d  = i_data;
            state_d = ST_TWO;
          end
        end
        ST_TWO: begin
          if (out_fire) begin
            main_d  = skid_q;
            state_d = ST_ONE;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_EMPTY;
      main_q  <= RST_DATA;
      skid_q  <= RST_DATA;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule
